// File: rtl/instr_rom_responder_if.sv
// Fetch and program-load bus between the MIPS core/loader (master) and the instruction ROM (slave).
interface instr_rom_responder_if;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        ld_en;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;

  modport master (output pc, ld_en, ld_valid, ld_data,
                  input  instr, instr_valid, ld_ready);
  modport slave  (input  pc, ld_en, ld_valid, ld_data,
                  output instr, instr_valid, ld_ready);
endinterface

// File: rtl/instr_rom_responder.sv
// Instruction ROM responder: program load port, PC-indexed fetch with optional wait states.
// Optional delivered-instruction counter enabled by INSTR_ROM_FETCH_CNT_EN.
module instr_rom_responder #(
  parameter int unsigned DEPTH_LOG2  = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] NOP_WORD    = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  instr_rom_responder_if.slave  bus,
  output logic                  load_done,
  output logic                  fault,
  output logic [31:0]           fetch_cnt
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {LOAD, FETCH, WAIT} state_t;

  state_t                state, state_d;
  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr, word_cnt;
  logic [3:0]            wait_cnt;
  logic [31:0]           pc_q;
  logic [31:0]           rdata_q;
  logic                  word_held;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  good, pc_changed;
  logic                  accept, start_wait, wait_done, present, enter_load;

  assign idx        = bus.pc[DEPTH_LOG2+1:2];
  // Full 30-bit word compare so addresses beyond the array never alias.
  assign good       = (bus.pc[1:0] == 2'b00) && (bus.pc[31:2] < 30'(word_cnt));
  // A fresh fetch is needed on PC change, or on first FETCH after a load.
  assign pc_changed = (bus.pc != pc_q) || !word_held;
  assign enter_load = (state != LOAD) && (state_d == LOAD);
  assign load_done  = (state == FETCH) && (word_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_d;
  end

  always_comb begin
    state_d         = state;
    accept          = 1'b0;
    start_wait      = 1'b0;
    wait_done       = 1'b0;
    present         = 1'b0;
    bus.ld_ready    = 1'b0;
    bus.instr       = NOP_WORD;
    bus.instr_valid = 1'b0;
    case (state)
      LOAD: begin
        bus.ld_ready = bus.ld_en && !wr_ptr[DEPTH_LOG2];
        accept       = bus.ld_ready && bus.ld_valid;
        if (!bus.ld_en) state_d = FETCH;
      end
      FETCH: begin
        if ((WAIT_STATES != 0) && pc_changed) begin
          if (!bus.ld_en) begin
            start_wait = 1'b1;
            state_d    = WAIT;
          end
        end else begin
          present         = 1'b1;
          bus.instr_valid = good;
          if (good) bus.instr = (WAIT_STATES == 0) ? mem[idx] : rdata_q;
        end
        if (bus.ld_en) state_d = LOAD;
      end
      WAIT: begin
        if (bus.ld_en) begin
          state_d = LOAD;
        end else if (bus.pc != pc_q) begin
          start_wait = 1'b1;
        end else if (wait_cnt <= 4'd1) begin
          wait_done = 1'b1;
          state_d   = FETCH;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      word_cnt  <= '0;
      wait_cnt  <= '0;
      fault     <= 1'b0;
      pc_q      <= '0;
      word_held <= 1'b0;
    end else begin
      pc_q <= bus.pc;
      if (enter_load) begin
        wr_ptr    <= '0;
        word_cnt  <= '0;
        word_held <= 1'b0;
      end else begin
        if (accept) begin
          wr_ptr   <= wr_ptr + 1'b1;
          word_cnt <= wr_ptr + 1'b1;
        end
        if (wait_done) word_held <= 1'b1;
      end
      if (state_d == LOAD)        fault <= 1'b0;
      else if (present && !good)  fault <= 1'b1;
      if (start_wait)             wait_cnt <= 4'(WAIT_STATES);
      else if (state == WAIT)     wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Program storage survives reset; only the word count is cleared.
  always_ff @(posedge clk) begin
    if (accept)    mem[wr_ptr[DEPTH_LOG2-1:0]] <= bus.ld_data;
    if (wait_done) rdata_q <= mem[idx];
  end

`ifdef INSTR_ROM_FETCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                    fetch_cnt <= '0;
    else if (enter_load)                           fetch_cnt <= '0;
    else if ((state == FETCH) && bus.instr_valid)  fetch_cnt <= fetch_cnt + 32'd1;
  end
`else
  assign fetch_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_rom_responder.sv
// Bench for instr_rom_responder: three instances (default, DEPTH_LOG2=2, WAIT_STATES=2) vs a behavioural model.
module tb_instr_rom_responder;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int unsigned LAT2 = 3;  // WAIT_STATES + 1
`ifdef INSTR_ROM_FETCH_CNT_EN
  localparam bit FC_EN = 1'b1;
`else
  localparam bit FC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_rom_responder_if b0 ();
  instr_rom_responder_if b1 ();
  instr_rom_responder_if b2 ();
  logic        ldn0, ldn1, ldn2, f0, f1, f2;
  logic [31:0] fc0, fc1, fc2;

  instr_rom_responder u0 (.clk(clk), .rst_n(rst_n), .bus(b0),
                          .load_done(ldn0), .fault(f0), .fetch_cnt(fc0));
  instr_rom_responder #(.DEPTH_LOG2(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1),
                          .load_done(ldn1), .fault(f1), .fetch_cnt(fc1));
  instr_rom_responder #(.WAIT_STATES(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2),
                          .load_done(ldn2), .fault(f2), .fetch_cnt(fc2));

  int checks = 0;
  int failures = 0;

  logic [31:0] spec_w [4] = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
  logic [31:0] wbuf [64];
  logic [31:0] m0 [256];
  logic [31:0] m2 [256];
  int unsigned cnt0 = 0, fcnt0 = 0, cnt2 = 0, fcnt2 = 0, age2 = 0;
  bit          fault0 = 1'b0, fault2 = 1'b0;
  logic [31:0] prev2 = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit good_f(input logic [31:0] pc, input int unsigned cnt);
    return (pc[1:0] == 2'b00) && ((pc >> 2) < cnt);
  endfunction

  function automatic logic [31:0] exp_fc(input int unsigned n);
    return FC_EN ? n : 32'd0;
  endfunction

  task automatic load0(input int unsigned n, input bit from_fetch);
    b0.ld_en = 1'b1;
    if (from_fetch) begin
      b0.ld_valid = 1'b1;
      b0.ld_data  = 32'hDEAD_BEEF;
      #1 chk("u0_ld_ready_transition", 32'(b0.ld_ready), 32'd0);
      tick;
    end
    for (int unsigned i = 0; i < n; i++) begin
      b0.ld_valid = 1'b1;
      b0.ld_data  = wbuf[i];
      #1 chk("u0_ld_ready", 32'(b0.ld_ready), 32'd1);
      tick;
      m0[i] = wbuf[i];
    end
    b0.ld_valid = 1'b0;
    b0.ld_en    = 1'b0;
    tick;
    cnt0 = n; fault0 = 1'b0; fcnt0 = 0;
  endtask

  task automatic fetch0(input logic [31:0] pc);
    bit g;
    b0.pc = pc;
    #1;
    g = good_f(pc, cnt0);
    chk("u0_instr", b0.instr, g ? m0[pc[9:2]] : NOP);
    chk("u0_instr_valid", 32'(b0.instr_valid), 32'(g));
    chk("u0_load_done", 32'(ldn0), 32'(cnt0 != 0));
    if (g) fcnt0++;
    tick;
    if (!g) fault0 = 1'b1;
    chk("u0_fault", 32'(f0), 32'(fault0));
    chk("u0_fetch_cnt", fc0, exp_fc(fcnt0));
  endtask

  task automatic step2(input logic [31:0] pc);
    bit g, v;
    if (pc != prev2) age2 = 0;
    b2.pc = pc;
    #1;
    g = good_f(pc, cnt2);
    v = g && (age2 >= LAT2);
    chk("u2_instr", b2.instr, v ? m2[pc[9:2]] : NOP);
    chk("u2_instr_valid", 32'(b2.instr_valid), 32'(v));
    if (v) fcnt2++;
    tick;
    if ((age2 >= LAT2) && !g) fault2 = 1'b1;
    chk("u2_fault", 32'(f2), 32'(fault2));
    chk("u2_fetch_cnt", fc2, exp_fc(fcnt2));
    age2++;
    prev2 = pc;
  endtask

  task automatic chk_reset0(input string tag);
    chk({tag, "_instr"}, b0.instr, NOP);
    chk({tag, "_instr_valid"}, 32'(b0.instr_valid), 32'd0);
    chk({tag, "_ld_ready"}, 32'(b0.ld_ready), 32'd0);
    chk({tag, "_load_done"}, 32'(ldn0), 32'd0);
    chk({tag, "_fault"}, 32'(f0), 32'd0);
    chk({tag, "_fetch_cnt"}, fc0, 32'd0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] wv [6];
    int unsigned n, sel, hold;
    logic [31:0] cand [7] = '{32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd6, 32'd40};

    b0.pc = '0; b0.ld_en = 1'b0; b0.ld_valid = 1'b0; b0.ld_data = '0;
    b1.pc = '0; b1.ld_en = 1'b1; b1.ld_valid = 1'b0; b1.ld_data = '0;
    b2.pc = '0; b2.ld_en = 1'b1; b2.ld_valid = 1'b0; b2.ld_data = '0;
    tick; tick;
    chk_reset0("reset");
    b0.ld_en = 1'b1;
    rst_n = 1'b1;
    tick;

    // Reference program, zero wait states
    for (int i = 0; i < 4; i++) wbuf[i] = spec_w[i];
    load0(4, 1'b0);
    for (int i = 0; i < 4; i++) fetch0(32'(i * 4));
    fetch0(32'd16);
    fetch0(32'd0);
    fetch0(32'd2);

    // Randomized program and fetch stream
    n = $urandom_range(5, 40);
    for (int unsigned i = 0; i < n; i++) wbuf[i] = $urandom;
    load0(n, 1'b1);
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0, 1, 2: pc = $urandom_range(0, n - 1) << 2;
        3:       pc = (n + $urandom_range(0, 300)) << 2;
        4:       pc = ($urandom_range(0, n - 1) << 2) | $urandom_range(1, 3);
        default: pc = 32'hFFFF_FFFC;
      endcase
      fetch0(pc);
    end

    // Ten delivered fetches, then an ld_en pulse clears the counter
    for (int i = 0; i < 4; i++) wbuf[i] = spec_w[i];
    load0(4, 1'b1);
    for (int i = 0; i < 10; i++) fetch0($urandom_range(0, 3) << 2);
    chk("fetch_cnt_10", fc0, exp_fc(10));
    b0.ld_en = 1'b1;
    tick;
    #1 chk("fetch_cnt_cleared", fc0, 32'd0);

    // Depth 4: only four of six offered words are taken
    for (int i = 0; i < 6; i++) wv[i] = $urandom;
    for (int i = 0; i < 6; i++) begin
      b1.ld_valid = 1'b1;
      b1.ld_data  = wv[i];
      #1 chk("u1_ld_ready", 32'(b1.ld_ready), 32'(i < 4));
      tick;
    end
    b1.ld_valid = 1'b0;
    b1.ld_en    = 1'b0;
    tick;
    b1.pc = 32'd12;
    #1 chk("u1_instr_pc12", b1.instr, wv[3]);
    chk("u1_valid_pc12", 32'(b1.instr_valid), 32'd1);
    chk("u1_load_done", 32'(ldn1), 32'd1);
    tick;
    chk("u1_fault_pc12", 32'(f1), 32'd0);
    b1.pc = 32'd16;
    #1 chk("u1_instr_pc16", b1.instr, NOP);
    chk("u1_valid_pc16", 32'(b1.instr_valid), 32'd0);
    tick;
    chk("u1_fault_pc16", 32'(f1), 32'd1);

    // Two wait states
    for (int i = 0; i < 4; i++) begin
      b2.ld_valid = 1'b1;
      b2.ld_data  = spec_w[i];
      tick;
      m2[i] = spec_w[i];
    end
    b2.ld_valid = 1'b0;
    b2.ld_en    = 1'b0;
    tick;
    cnt2 = 4; age2 = 0; prev2 = b2.pc;
    for (int i = 0; i < 4; i++) step2(32'd0);
    for (int i = 0; i < 4; i++) step2(32'd4);
    step2(32'd8);
    step2(32'd8);
    for (int i = 0; i < 4; i++) step2(32'd12);
    for (int i = 0; i < 15; i++) begin
      pc = cand[$urandom_range(0, 6)];
      hold = $urandom_range(1, 5);
      for (int unsigned k = 0; k < hold; k++) step2(pc);
    end

    // Reset in the middle of a load
    b0.ld_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      b0.ld_data = $urandom;
      tick;
    end
    rst_n = 1'b0;
    b0.ld_en = 1'b0;
    b0.ld_valid = 1'b0;
    #1 chk_reset0("mid_load_reset");
    tick;
    b0.ld_en = 1'b1;
    rst_n = 1'b1;
    cnt0 = 0; fault0 = 1'b0; fcnt0 = 0;
    wbuf[0] = 32'h12345678;
    load0(1, 1'b0);
    fetch0(32'd0);
    chk("reload_fault_clear", 32'(f0), 32'd0);
    fetch0(32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
